trace_buffer: RTL

- Parametrised hardware trace capture unit that sits beside the single-cycle RISC-V core inside top.
- Samples the core's pc/instr/aluresult/writedata/memwrite each clock into a circular buffer.
- Supports three capture modes: all instructions, stores only, and PC-triggered with pre/post history.
- Detects a self-loop halt to end capture, then drains the buffer oldest-first over a valid/ready port.

---
 rtl/trace_buffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// Trace capture unit: samples core activity into a circular buffer (all / stores / PC-triggered),
// stops on disable, self-loop halt or trigger post-count, then drains oldest-first over valid/ready.
module trace_buffer #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [$clog2(DEPTH):0]   post_count,
    input  logic [XLEN-1:0]          pc,
    input  logic [XLEN-1:0]          instr,
    input  logic [XLEN-1:0]          aluresult,
    input  logic [XLEN-1:0]          writedata,
    input  logic                     memwrite,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
    output logic [XLEN-1:0]          rd_data,
    output logic                     rd_memwrite,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(HALT_CYCLES + 1);
    localparam int EW = 3 * XLEN + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;
    localparam logic [1:0] M_ALL     = 2'd0;
    localparam logic [1:0] M_STORES  = 2'd1;
    localparam logic [1:0] M_TRIGGER = 2'd2;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, post_q, post_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic            overflow_q, overflow_d, halted_q, halted_d;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   rd_entry_q;
    logic [EW-1:0]   wr_entry;

    logic            active, dup, halt_ev, trig_hit, rec, pop, full;
    logic [CW-1:0]   post_load;

    assign active    = ((state_q == S_ARMED) || (state_q == S_CAPTURE)) && en;
    assign dup       = (pc == prev_pc_q);
    assign halt_ev   = active && dup && (stall_q == SW'(HALT_CYCLES - 1));
    assign trig_hit  = (state_q == S_ARMED) && en && (pc == trig_pc) && !halt_ev;
    // The trigger sample is forced in so it is kept even when it looks like a repeat.
    assign rec       = active && ((mode_q == M_STORES) ? memwrite : (!dup || trig_hit));
    assign pop       = (state_q == S_DRAIN) && (count_q != '0) && rd_ready;
    assign full      = (count_q == CW'(DEPTH));
    assign post_load = (post_count > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_count;
    assign wr_entry  = {pc, instr, (mode_q == M_STORES) ? writedata : aluresult, memwrite};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= M_ALL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            stall_q    <= '0;
            prev_pc_q  <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            stall_q    <= stall_d;
            prev_pc_q  <= prev_pc_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        stall_d    = stall_q;
        prev_pc_d  = prev_pc_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    mode_d     = (mode == M_TRIGGER || mode == M_STORES) ? mode : M_ALL;
                    state_d    = (mode == M_TRIGGER) ? S_ARMED : S_CAPTURE;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    post_d     = '0;
                    stall_d    = '0;
                    prev_pc_d  = '0;
                    overflow_d = 1'b0;
                    halted_d   = 1'b0;
                end
            end
            S_ARMED, S_CAPTURE: begin
                if (!en) begin
                    state_d = S_DRAIN;
                end else begin
                    prev_pc_d = pc;
                    if (!dup)
                        stall_d = '0;
                    else if (stall_q != SW'(HALT_CYCLES - 1))
                        stall_d = stall_q + 1'b1;
                    if (rec) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (full) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (halt_ev) begin
                        halted_d = 1'b1;
                        state_d  = S_DRAIN;
                    end else if (trig_hit) begin
                        post_d  = post_load;
                        state_d = (post_load == '0) ? S_DRAIN : S_CAPTURE;
                    end else if (state_q == S_CAPTURE && mode_q == M_TRIGGER && rec) begin
                        post_d = post_q - 1'b1;
                        if (post_q == CW'(1))
                            state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    if (count_q == CW'(1))
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rec)
            mem[wr_ptr_q] <= wr_entry;
    end

    // Registered read addressed by the next read pointer; bypass covers a write into the head slot.
    always_ff @(posedge clk) begin
        if (rst)
            rd_entry_q <= '0;
        else if (rec && (wr_ptr_q == rd_ptr_d))
            rd_entry_q <= wr_entry;
        else
            rd_entry_q <= mem[rd_ptr_d];
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        rd_valid    = (state_q == S_DRAIN) && (count_q != '0);
        rd_pc       = rd_valid ? rd_entry_q[3*XLEN -: XLEN] : '0;
        rd_instr    = rd_valid ? rd_entry_q[2*XLEN -: XLEN] : '0;
        rd_data     = rd_valid ? rd_entry_q[XLEN -: XLEN] : '0;
        rd_memwrite = rd_valid && rd_entry_q[0];
        rd_last     = rd_valid && (count_q == CW'(1));
        count       = count_q;
        overflow    = overflow_q;
        halted      = halted_q;
    end
endmodule
